memory_arbiter: RTL and testbench

Memory-side responder for the processor's request interface. Accepts the instruction fetch request (imemREN) and data requests (dmemREN/dmemWEN), arbitrates them onto a single-port RAM, and returns single-cycle ihit/dhit strobes with load data. It sits between the datapath's request logic and the RAM model, and is the sole driver of the RAM control port.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/mem_arb_timer.sv | 39 +++
 rtl/memory_arbiter.sv | 125 ++++++++++++
 tb/tb_memory_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the processor/memory interface: the word type, the RAM
// handshake state and the memory arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // State reported by the RAM model on its control port.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter grant state: IDLE decides, DATA/INSTR own the RAM port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait counter for a granted access. Cleared while the arbiter is idle, so it
// starts from zero on entry to a grant state, and counts every cycle the RAM
// has not answered. timeout fires in the cycle the count reaches TIMEOUT.
module mem_arb_timer #(
  parameter int TIMEOUT = 64,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear when idle, otherwise saturating increment while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // The cycle that would bring the count to TIMEOUT is the abort cycle.
  assign timeout = !clear && count_en && (cnt_q == CW'(TIMEOUT - 1));

  // Count register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Memory arbiter: grants the single-port RAM to either the data or the
// instruction requester, returns one-cycle ihit/dhit strobes with load data,
// and pulses merr when an access is aborted.
// Optional feature macro: MEM_ARB_TIMEOUT_EN adds a wait-counter abort after
// TIMEOUT cycles without RAM ACCESS; without it the arbiter waits forever.
//
// Handshake: a requester holds its enable until it sees its hit. A hit is the
// single completion strobe; the data requester clears its enables the cycle
// after dhit, so the arbiter ignores data requests for that one cycle
// (holdoff) to avoid granting the stale request again.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      imemREN,
  input  word_t     imemaddr,
  output word_t     imemload,
  output logic      ihit,
  input  logic      dmemREN,
  input  logic      dmemWEN,
  input  word_t     dmemaddr,
  input  word_t     dmemstore,
  output word_t     dmemload,
  output logic      dhit,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      merr
);

  arb_state_t state_q, state_d;
  logic       holdoff_q, holdoff_d;
  logic       timeout;
  logic       dreq;

  assign dreq = dmemREN | dmemWEN;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (state_q == IDLE),
    .count_en (ramstate != ACCESS),
    .timeout  (timeout)
  );
`else
  // No abort timer: TIMEOUT is kept only so both builds share one parameter list.
  assign timeout = 1'b0 & (TIMEOUT == 0);
`endif

  // Grant decision, RAM port drive and completion strobes for the current state.
  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    merr     = 1'b0;
    imemload = '0;
    dmemload = '0;
    unique case (state_q)
      IDLE: begin
        if (dreq && !holdoff_q) begin
          state_d = DATA;
        end else if (imemREN) begin
          state_d = INSTR;
        end
      end
      DATA: begin
        ramaddr  = dmemaddr;
        ramstore = dmemstore;
        ramWEN   = dmemWEN;
        ramREN   = dmemREN & ~dmemWEN;
        if (!dreq) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dhit     = 1'b1;
          dmemload = ramload;
          state_d  = IDLE;
        end else if ((ramstate == ERROR) || timeout) begin
          merr    = 1'b1;
          state_d = IDLE;
        end
      end
      INSTR: begin
        ramaddr = imemaddr;
        ramREN  = 1'b1;
        if (!imemREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          ihit     = 1'b1;
          imemload = ramload;
          state_d  = IDLE;
        end else if ((ramstate == ERROR) || timeout) begin
          merr    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    holdoff_d = dhit;
  end

  // FSM state and holdoff registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      holdoff_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= holdoff_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed request sequences drive the arbiter, each
// expected hit/merr event is queued when its stimulus is applied, and a
// negedge monitor pops and compares every event the arbiter produces.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      RST;
  logic      imemREN;
  word_t     imemaddr;
  word_t     imemload;
  logic      ihit;
  logic      dmemREN;
  logic      dmemWEN;
  word_t     dmemaddr;
  word_t     dmemstore;
  word_t     dmemload;
  logic      dhit;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      merr;

  int total;
  int bad;

  // Event encoding: {kind[1:0], data[31:0]}; kind 01=ihit, 10=dhit, 11=merr.
  logic [33:0] exp_q[$];
  logic [33:0] mon_obs;
  logic [33:0] mon_exp;

  localparam logic [1:0] EV_I = 2'b01;
  localparam logic [1:0] EV_D = 2'b10;
  localparam logic [1:0] EV_E = 2'b11;

  memory_arbiter #(
    .TIMEOUT (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .imemload  (imemload),
    .ihit      (ihit),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .dmemload  (dmemload),
    .dhit      (dhit),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .merr      (merr)
  );

  // Clock and watchdog.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic push(input logic [1:0] kind, input word_t data);
    exp_q.push_back({kind, data});
  endtask

  // Scoreboard monitor: every hit/merr must match the head of the expected queue.
  always @(negedge CLK) begin
    if (!RST) begin
      if (ihit | dhit | merr) begin
        check("one_event", 64'(ihit) + 64'(dhit) + 64'(merr), 64'd1);
        mon_obs = {merr | dhit, merr | ihit, (ihit ? imemload : dmemload)};
        if (exp_q.size() == 0) begin
          check("unexpected_event", 64'(mon_obs), 64'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sb_event", 64'(mon_obs), 64'(mon_exp));
        end
      end
      if (!ihit) check("imemload_zero", 64'(imemload), 64'd0);
      if (!dhit) check("dmemload_zero", 64'(dmemload), 64'd0);
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    // Reset with every request asserted.
    RST       = 1'b1;
    imemREN   = 1'b1;
    dmemREN   = 1'b1;
    dmemWEN   = 1'b1;
    imemaddr  = 32'h80;
    dmemaddr  = 32'h100;
    dmemstore = 32'hCAFE_F00D;
    ramload   = 32'hFFFF_FFFF;
    ramstate  = ACCESS;
    repeat (2) @(posedge CLK);
    sample();
    check("rst_ramREN", 64'(ramREN), 64'd0);
    check("rst_ramWEN", 64'(ramWEN), 64'd0);
    check("rst_hits", 64'({ihit, dhit, merr}), 64'd0);
    check("rst_ramaddr", 64'(ramaddr), 64'd0);
    check("rst_ramstore", 64'(ramstore), 64'd0);
    check("rst_loads", {imemload, dmemload}, 64'd0);

    // Release: data request wins over instruction at the next edge.
    tick();
    dmemWEN  = 1'b0;
    ramstate = BUSY;
    RST      = 1'b0;
    sample();
    check("rel_idle", 64'(ramREN), 64'd0);
    tick();
    ramstate = ACCESS;
    ramload  = 32'h1111_2222;
    push(EV_D, 32'h1111_2222);
    sample();
    check("rel_data_grant", 64'({ramREN, ramWEN}), 64'b10);
    check("rel_data_addr", 64'(ramaddr), 64'h100);
    check("rel_dhit", 64'(dhit), 64'd1);
    // dmemREN held one extra cycle: holdoff blocks a second data grant.
    tick();
    ramstate = BUSY;
    sample();
    check("hold_idle", 64'({ramREN, dhit}), 64'd0);
    tick();
    dmemREN  = 1'b0;
    ramstate = ACCESS;
    ramload  = 32'h3333_4444;
    push(EV_I, 32'h3333_4444);
    sample();
    check("hold_instr_addr", 64'(ramaddr), 64'h80);
    check("hold_instr_ren", 64'(ramREN), 64'd1);
    tick();
    imemREN  = 1'b0;
    ramstate = BUSY;
    sample();
    check("hold_back_idle", 64'(ramREN), 64'd0);

    // Instruction fetch with three BUSY cycles before ACCESS.
    tick();
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    ramload  = 32'h8C01_0004;
    sample();
    tick();
    sample();
    check("if_grant_addr", 64'(ramaddr), 64'h40);
    check("if_grant_ren", 64'(ramREN), 64'd1);
    check("if_no_hit_1", 64'(ihit), 64'd0);
    repeat (2) tick();
    sample();
    check("if_no_hit_3", 64'(ihit), 64'd0);
    tick();
    ramstate = ACCESS;
    push(EV_I, 32'h8C01_0004);
    sample();
    check("if_ihit", 64'(ihit), 64'd1);
    check("if_load", 64'(imemload), 64'h8C01_0004);
    tick();
    imemREN  = 1'b0;
    ramstate = BUSY;
    sample();
    check("if_pulse_end", 64'(ihit), 64'd0);

    // Back-to-back instruction fetches: hit, IDLE, hit.
    tick();
    imemREN  = 1'b1;
    imemaddr = 32'h44;
    ramstate = ACCESS;
    ramload  = 32'h0000_0001;
    push(EV_I, 32'h0000_0001);
    push(EV_I, 32'h0000_0002);
    sample();
    tick();
    sample();
    check("b2b_hit1", 64'(ihit), 64'd1);
    tick();
    ramload = 32'h0000_0002;
    sample();
    check("b2b_gap", 64'({ihit, ramREN}), 64'd0);
    tick();
    sample();
    check("b2b_hit2", 64'(ihit), 64'd1);
    tick();
    imemREN  = 1'b0;
    ramstate = BUSY;
    sample();

    // Write wins when both data enables are high.
    tick();
    dmemREN   = 1'b1;
    dmemWEN   = 1'b1;
    dmemaddr  = 32'h200;
    dmemstore = 32'hDEAD_BEEF;
    sample();
    tick();
    sample();
    check("wr_enables", 64'({ramWEN, ramREN}), 64'b10);
    check("wr_store", 64'(ramstore), 64'hDEAD_BEEF);
    check("wr_addr", 64'(ramaddr), 64'h200);
    tick();
    ramstate = ACCESS;
    ramload  = 32'h5555_AAAA;
    push(EV_D, 32'h5555_AAAA);
    sample();
    check("wr_dhit", 64'(dhit), 64'd1);
    tick();
    dmemREN  = 1'b0;
    dmemWEN  = 1'b0;
    ramstate = BUSY;
    sample();

    // RAM ERROR during DATA: merr, no hit, request granted again after IDLE.
    tick();
    dmemREN  = 1'b1;
    dmemaddr = 32'h300;
    ramstate = ERROR;
    sample();
    tick();
    push(EV_E, 32'h0);
    sample();
    check("err_merr", 64'({merr, dhit}), 64'b10);
    tick();
    ramstate = BUSY;
    sample();
    check("err_idle", 64'({ramREN, merr}), 64'd0);
    tick();
    sample();
    check("err_regrant", 64'(ramREN), 64'd1);
    check("err_regrant_addr", 64'(ramaddr), 64'h300);
    tick();
    ramstate = ACCESS;
    ramload  = 32'hA5A5_A5A5;
    push(EV_D, 32'hA5A5_A5A5);
    sample();
    tick();
    dmemREN  = 1'b0;
    ramstate = BUSY;
    sample();

    // Enable dropped while granted: back to IDLE with no hit.
    tick();
    dmemREN  = 1'b1;
    dmemaddr = 32'h400;
    sample();
    tick();
    dmemREN  = 1'b0;
    ramstate = ACCESS;
    sample();
    check("drop_no_hit", 64'(dhit), 64'd0);
    tick();
    ramstate = BUSY;
    sample();
    check("drop_idle", 64'(ramREN), 64'd0);

    // RAM stuck BUSY during DATA.
    tick();
    dmemREN  = 1'b1;
    dmemaddr = 32'h500;
    sample();
`ifdef MEM_ARB_TIMEOUT_EN
    tick();
    sample();
    check("to_no_merr_1", 64'(merr), 64'd0);
    repeat (2) tick();
    sample();
    check("to_no_merr_3", 64'(merr), 64'd0);
    tick();
    push(EV_E, 32'h0);
    sample();
    check("to_merr", 64'(merr), 64'd1);
    tick();
    dmemREN = 1'b0;
    sample();
    check("to_idle", 64'(ramREN), 64'd0);
`else
    repeat (12) tick();
    sample();
    check("stall_still_granted", 64'(ramREN), 64'd1);
    check("stall_no_merr", 64'(merr), 64'd0);
    tick();
    dmemREN = 1'b0;
    sample();
    tick();
    sample();
    check("stall_idle", 64'(ramREN), 64'd0);
`endif

    // Reset in the middle of a DATA access.
    tick();
    dmemREN  = 1'b1;
    dmemaddr = 32'h600;
    sample();
    tick();
    sample();
    check("mid_rst_granted", 64'(ramREN), 64'd1);
    #2;
    RST      = 1'b1;
    ramstate = ACCESS;
    #1;
    check("mid_rst_ren", 64'(ramREN), 64'd0);
    check("mid_rst_nohit", 64'({dhit, merr}), 64'd0);
    check("mid_rst_addr", 64'(ramaddr), 64'd0);
    tick();
    dmemREN  = 1'b0;
    ramstate = BUSY;
    RST      = 1'b0;
    sample();
    check("post_rst_idle", 64'(ramREN), 64'd0);
    tick();
    sample();

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
